// File: rtl/mul_pkg.sv
// Shared types and op encodings for the iterative RV32M multiplier.
package mul_pkg;

    localparam logic [1:0] OpEncMul    = 2'b00;
    localparam logic [1:0] OpEncMulh   = 2'b01;
    localparam logic [1:0] OpEncMulhsu = 2'b10;
    localparam logic [1:0] OpEncMulhu  = 2'b11;

    typedef enum logic [1:0] {
        OpMul    = OpEncMul,
        OpMulh   = OpEncMulh,
        OpMulhsu = OpEncMulhsu,
        OpMulhu  = OpEncMulhu
    } mul_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } mul_state_t;

    function automatic logic op_signed_a(input mul_op_t op);
        return (op == OpMulh) || (op == OpMulhsu);
    endfunction

    function automatic logic op_signed_b(input mul_op_t op);
        return op == OpMulh;
    endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/response handshake bundle between the execute stage and mul_iter.
interface mul_iter_if #(
    parameter int unsigned N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul_sign_fix.sv
// Sign handling for mul_iter: operand magnitudes at accept time, and the
// conditional 2N-bit negate plus half select when the product completes.
module mul_sign_fix
    import mul_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  mul_op_t        op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   abs_a,
    output logic [N-1:0]   abs_b,
    output logic           neg,
    input  mul_op_t        done_op,
    input  logic           done_neg,
    input  logic [2*N-1:0] acc,
    output logic [N-1:0]   result
);
    logic           neg_a;
    logic           neg_b;
    logic [2*N-1:0] prod;

    always_comb begin
        neg_a = op_signed_a(op) & a[N-1];
        neg_b = op_signed_b(op) & b[N-1];
        // Negating the most negative value wraps to 2^(N-1), read as unsigned.
        abs_a = neg_a ? -a : a;
        abs_b = neg_b ? -b : b;
        neg   = neg_a ^ neg_b;
    end

    always_comb begin
        prod   = done_neg ? -acc : acc;
        result = (done_op == OpMul) ? prod[N-1:0] : prod[2*N-1:N];
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add RV32M multiplier, one multiplier bit per cycle.
// Define MUL_ITER_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module mul_iter
    import mul_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input logic        clk,
    input logic        rst_n,
    mul_iter_if.slave  bus
);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    mul_state_t     state_q;
    logic [CW-1:0]  count_q;
    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic           neg_q;
    mul_op_t        op_q;
    logic [N-1:0]   result_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    mul_op_t        in_op;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic           lat_neg;
    logic [N-1:0]   fix_result;
    logic [2*N-1:0] acc_step;
    logic [N-1:0]   mplier_post;
    logic           last_step;

    assign in_op = mul_op_t'(bus.op);

    mul_sign_fix #(
        .N (N)
    ) u_sign_fix (
        .op       (in_op),
        .a        (bus.a),
        .b        (bus.b),
        .abs_a    (abs_a),
        .abs_b    (abs_b),
        .neg      (lat_neg),
        .done_op  (op_q),
        .done_neg (neg_q),
        .acc      (acc_step),
        .result   (fix_result)
    );

    // The sign fix sees the accumulator including the current step, so the
    // result can be registered on the same edge that enters DONE.
    always_comb begin
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_post = mplier_q >> 1;
`ifdef MUL_ITER_EARLY_TERM_EN
        last_step   = (count_q == CntLast) || (mplier_post == '0);
`else
        last_step   = (count_q == CntLast);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            op_q        <= OpMul;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        mcand_q    <= {{N{1'b0}}, abs_a};
                        mplier_q   <= abs_b;
                        neg_q      <= lat_neg;
                        op_q       <= in_op;
                        acc_q      <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_post;
                    count_q  <= count_q + 1'b1;
                    if (last_step) begin
                        result_q    <= fix_result;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vector table, reset and
// backpressure sequences, then randomized traffic against a 64-bit product model.
module tb_mul_iter;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_iter_if #(.N(N)) bus ();

    mul_iter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: extend each operand per its signedness and take the full product.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_ITER_EARLY_TERM_EN
        logic [31:0] mag;
        int hi;
        mag = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
        hi  = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
`else
        return 32;
`endif
    endfunction

    // One complete transaction; ok is cleared on any handshake misbehaviour.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int rdy_dly, input bit noise,
                          output logic [31:0] res, output int lat, output bit ok);
        int guard;
        ok    = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready || !bus.busy) ok = 1'b0;
            if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.op        = 2'($urandom_range(0, 3));
                bus.a         = $urandom;
                bus.b         = $urandom;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        bus.out_ready = 1'b0;
        repeat (rdy_dly) begin
            bus.in_valid = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || !bus.busy || bus.result !== res) ok = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (bus.out_valid || !bus.in_ready || bus.busy) ok = 1'b0;
    endtask

    vec_t        vecs[12];
    logic [31:0] res;
    int          lat;
    bit          ok;
    bit          stray;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corner[4];

    initial begin
        vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[6]  = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[7]  = '{2'b01, 32'h8765_4321, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        corner = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset result", bus.result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, res, lat, ok);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
            check($sformatf("vec%0d handshake", i), ok, 1);
        end

        // Reset mid-BUSY discards the operation.
        bus.in_valid = 1'b1;
        bus.op = 2'b00;
        bus.a  = 32'd7;
        bus.b  = 32'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`ifdef MUL_ITER_EARLY_TERM_EN
        repeat (1) @(posedge clk);
`else
        repeat (10) @(posedge clk);
`endif
        #1;
        check("midrst busy before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", bus.in_ready, 1);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst result", bus.result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) stray = 1'b1;
        end
        check("midrst no stray result", stray, 0);
        run_op(2'b00, 32'd7, 32'd6, 0, 1'b0, res, lat, ok);
        check("post-reset result", res, 32'h2A);
        check("post-reset handshake", ok, 1);

        // Backpressure: result held for 5 cycles while in_valid is asserted.
        run_op(2'b01, 32'hFFFF_FFF9, 32'h0000_0006, 5, 1'b0, res, lat, ok);
        check("bp result", res, 32'hFFFF_FFFF);
        check("bp handshake", ok, 1);

        for (int k = 0; k < 1500; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 5))
                0: rb = corner[$urandom_range(0, 3)];
                1: rb = $urandom_range(0, 255);
                default: rb = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'b1, res, lat, ok);
            check($sformatf("rnd%0d op%0d %h*%h", k, rop, ra, rb), res, ref_mul(rop, ra, rb));
            check($sformatf("rnd%0d latency", k), lat, exp_lat(rop, rb));
            check($sformatf("rnd%0d handshake", k), ok, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
